// File: rtl/cpu_pkg.sv
// Shared encodings for the COA CPU control path: opcodes, ALU operations, FSM states.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JZ    = 4'h7;
  localparam logic [3:0] OP_OUT   = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;

  typedef enum logic [2:0] {
    START  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    FAULT  = 3'd7
  } state_t;

  // Non-arithmetic opcodes map to PASS so alu_op stays 0 outside ALU instructions.
  function automatic logic [2:0] alu_of(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request waits; flags the cycle that would reach WAIT_MAX.
module mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(WAIT_MAX + 1);

  logic [W-1:0] cnt;

  // Any cycle without a pending, unanswered request clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
    else         cnt <= '0;
  end

  assign expired = en && (cnt == W'(WAIT_MAX - 1));

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit for the 8-bit COA CPU: fetch/decode/execute sequencing,
// memory handshake with timeout, HALT/fault detection and a retired-instruction counter.
//
// state  | meaning
// START  | idle after reset, waits for go
// FETCH  | read instruction at PC into IR
// DECODE | dispatch on opcode; jumps/OUT/NOP complete here
// EXEC   | ALU operation for ADD/SUB/AND
// MEM    | data access at IR operand for LOAD/STORE
// WB     | accumulator and zero-flag write-back
// HALT   | HALT executed, parked until reset
// FAULT  | illegal opcode or memory timeout, parked until reset
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [3:0]       opcode,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_ld,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [2:0]       alu_op,
  output logic             wb_sel,
  output logic             reg_we,
  output logic             flag_we,
  output logic             out_ld,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t state, state_n;
  logic   retire;
  logic   waiting;
  logic   expired;

  // Derived from state directly so the timer does not loop through the output decode.
  assign waiting = ((state == FETCH) || (state == MEM)) && !mem_ready;

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (waiting),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= START;
      halted    <= 1'b0;
      fault     <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state <= state_n;
      if (state_n == HALT)  halted    <= 1'b1;
      if (state_n == FAULT) fault     <= 1'b1;
      if (retire)           instr_cnt <= instr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    retire   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_ld    = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    alu_op   = ALU_PASS;
    wb_sel   = 1'b0;
    reg_we   = 1'b0;
    flag_we  = 1'b0;
    out_ld   = 1'b0;

    case (state)
      START: begin
        if (go) state_n = FETCH;
      end

      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
          state_n = DECODE;
        end else if (expired) begin
          state_n = FAULT;
        end
      end

      DECODE: begin
        case (opcode)
          OP_NOP: begin
            state_n = FETCH;
            retire  = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: state_n = EXEC;
          OP_LOAD, OP_STORE:      state_n = MEM;
          OP_JMP: begin
            pc_load = 1'b1;
            state_n = FETCH;
            retire  = 1'b1;
          end
          OP_JZ: begin
            pc_load = zero_flag;
            state_n = FETCH;
            retire  = 1'b1;
          end
          OP_OUT: begin
            out_ld  = 1'b1;
            state_n = FETCH;
            retire  = 1'b1;
          end
          OP_HALT: begin
            state_n = HALT;
            retire  = 1'b1;
          end
          default: state_n = FAULT;
        endcase
      end

      EXEC: begin
        alu_op  = alu_of(opcode);
        state_n = WB;
      end

      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            state_n = FETCH;
            retire  = 1'b1;
          end else begin
            wb_sel  = 1'b1;
            state_n = WB;
          end
        end else if (expired) begin
          state_n = FAULT;
        end
      end

      WB: begin
        reg_we  = 1'b1;
        flag_we = 1'b1;
        wb_sel  = (opcode == OP_LOAD);
        alu_op  = alu_of(opcode);
        state_n = FETCH;
        retire  = 1'b1;
      end

      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Randomized self-checking bench for cpu_ctrl_fsm; expected per-cycle control words
// are generated from the instruction-level timing rules of each opcode.
module tb_cpu_ctrl_fsm;
  import cpu_pkg::*;

  localparam int CNT_W    = 8;
  localparam int WAIT_MAX = 15;

  localparam logic [12:0] C_REQ   = 13'h1000;
  localparam logic [12:0] C_WE    = 13'h0800;
  localparam logic [12:0] C_ASEL  = 13'h0400;
  localparam logic [12:0] C_IRLD  = 13'h0200;
  localparam logic [12:0] C_PCINC = 13'h0100;
  localparam logic [12:0] C_PCLD  = 13'h0080;
  localparam logic [12:0] C_WBSEL = 13'h0008;
  localparam logic [12:0] C_REGWE = 13'h0004;
  localparam logic [12:0] C_FLGWE = 13'h0002;
  localparam logic [12:0] C_OUTLD = 13'h0001;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             go = 1'b0;
  logic [3:0]       opcode = 4'h0;
  logic             zero_flag = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_load;
  logic [2:0]       alu_op;
  logic             wb_sel, reg_we, flag_we, out_ld, halted, fault;
  logic [CNT_W-1:0] instr_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_cnt = 0;
  bit exp_halted = 1'b0;
  bit exp_fault  = 1'b0;

  cpu_ctrl_fsm #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .opcode    (opcode),
    .zero_flag (zero_flag),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_ld     (ir_ld),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .alu_op    (alu_op),
    .wb_sel    (wb_sel),
    .reg_we    (reg_we),
    .flag_we   (flag_we),
    .out_ld    (out_ld),
    .halted    (halted),
    .fault     (fault),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  wire [12:0] ctrl = {mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_load,
                      alu_op, wb_sel, reg_we, flag_we, out_ld};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // One cycle: drive inputs after the falling edge, check the control word before the rising edge.
  task automatic step(input logic [12:0] exp, input logic rdy, input logic [3:0] op,
                      input logic zf, input string tag);
    @(negedge clk);
    mem_ready = rdy;
    opcode    = op;
    zero_flag = zf;
    #1;
    check(tag, 32'(ctrl), 32'(exp));
  endtask

  task automatic check_status(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_cnt"},    32'(instr_cnt), 32'(exp_cnt));
    check({tag, "_halted"}, 32'(halted),    32'(exp_halted));
    check({tag, "_fault"},  32'(fault),     32'(exp_fault));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    go = 1'b0;
    mem_ready = 1'b0;
    exp_cnt = 0;
    exp_halted = 1'b0;
    exp_fault = 1'b0;
    #1;
    check("rst_ctrl", 32'(ctrl), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_cnt",    32'(instr_cnt), 32'(0));
    check("rst_halted", 32'(halted),    32'(0));
    check("rst_fault",  32'(fault),     32'(0));
  endtask

  task automatic start_run();
    @(negedge clk);
    go = 1'b1;
    mem_ready = 1'($urandom);
    #1;
    check("start_ctrl", 32'(ctrl), 32'(0));
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  function automatic logic [12:0] alu_word(input logic [3:0] op);
    case (op)
      OP_ADD:  return 13'(1) << 4;
      OP_SUB:  return 13'(2) << 4;
      OP_AND:  return 13'(3) << 4;
      default: return 13'(0);
    endcase
  endfunction

  task automatic retire_one();
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
  endtask

  // fl/ml: wait cycles before mem_ready in FETCH / MEM (must stay below WAIT_MAX).
  task automatic run_instr(input logic [3:0] op, input int fl, input int ml, input logic zf);
    logic [12:0] dec;
    for (int i = 0; i < fl; i++) step(C_REQ, 1'b0, 4'($urandom), 1'($urandom), "fetch_wait");
    step(C_REQ | C_IRLD | C_PCINC, 1'b1, 4'($urandom), 1'($urandom), "fetch");
    dec = '0;
    if (op == OP_JMP) dec = C_PCLD;
    if (op == OP_JZ && zf) dec = C_PCLD;
    if (op == OP_OUT) dec = C_OUTLD;
    step(dec, 1'($urandom), op, zf, "decode");
    case (op)
      OP_ADD, OP_SUB, OP_AND: begin
        step(alu_word(op), 1'($urandom), op, zf, "exec");
        step(alu_word(op) | C_REGWE | C_FLGWE, 1'($urandom), op, zf, "wb");
        retire_one();
      end
      OP_LOAD: begin
        for (int i = 0; i < ml; i++) step(C_REQ | C_ASEL, 1'b0, op, zf, "load_wait");
        step(C_REQ | C_ASEL | C_WBSEL, 1'b1, op, zf, "load_mem");
        step(C_REGWE | C_FLGWE | C_WBSEL, 1'($urandom), op, zf, "load_wb");
        retire_one();
      end
      OP_STORE: begin
        for (int i = 0; i < ml; i++) step(C_REQ | C_WE | C_ASEL, 1'b0, op, zf, "store_wait");
        step(C_REQ | C_WE | C_ASEL, 1'b1, op, zf, "store_mem");
        retire_one();
      end
      OP_NOP, OP_JMP, OP_JZ, OP_OUT: retire_one();
      OP_HALT: begin
        retire_one();
        exp_halted = 1'b1;
      end
      default: exp_fault = 1'b1;
    endcase
    check_status("instr");
  endtask

  // After HALT/FAULT every output stays 0 and go has no effect.
  task automatic parked(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      go = 1'($urandom);
      step(13'h0, 1'($urandom), 4'($urandom), 1'($urandom), tag);
    end
    go = 1'b0;
    check_status(tag);
  endtask

  initial begin
    logic [3:0] legal [9];
    legal = '{OP_NOP, OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_JMP, OP_JZ, OP_OUT};

    do_reset();
    repeat (2) step(13'h0, 1'($urandom), 4'($urandom), 1'($urandom), "start_idle");
    start_run();

    run_instr(OP_LOAD, 0, 0, 1'b0);
    run_instr(OP_ADD,  0, 0, 1'b0);
    run_instr(OP_OUT,  0, 0, 1'b0);
    check("prog_cnt", 32'(instr_cnt), 32'(3));

    run_instr(OP_JZ, 0, 0, 1'b1);
    run_instr(OP_JZ, 0, 0, 1'b0);
    run_instr(OP_STORE, 0, 3, 1'b0);

    // Threshold cycle: ready arrives as the wait count would hit WAIT_MAX.
    run_instr(OP_LOAD, WAIT_MAX - 1, WAIT_MAX - 1, 1'b0);

    for (int k = 0; k < 60; k++) begin
      logic [3:0] op;
      int fl, ml;
      op = legal[$urandom_range(0, 8)];
      fl = ($urandom_range(0, 7) == 0) ? WAIT_MAX - 1 : $urandom_range(0, 2);
      ml = ($urandom_range(0, 7) == 0) ? WAIT_MAX - 1 : $urandom_range(0, 3);
      run_instr(op, fl, ml, 1'($urandom));
    end

    run_instr(OP_HALT, 1, 0, 1'b0);
    parked(6, "halt_park");

    do_reset();
    start_run();
    run_instr(OP_NOP, 0, 0, 1'b0);
    run_instr(4'hB, 0, 0, 1'b0);
    check("illegal_cnt", 32'(instr_cnt), 32'(1));
    parked(4, "illegal_park");

    do_reset();
    start_run();
    for (int i = 0; i < WAIT_MAX; i++) step(C_REQ, 1'b0, 4'($urandom), 1'($urandom), "fto_wait");
    exp_fault = 1'b1;
    step(13'h0, 1'b1, 4'($urandom), 1'($urandom), "fto_fault");
    parked(5, "fto_park");

    do_reset();
    start_run();
    run_instr(OP_NOP, 0, 0, 1'b0);
    step(C_REQ | C_IRLD | C_PCINC, 1'b1, 4'($urandom), 1'b0, "mto_fetch");
    step(13'h0, 1'b0, OP_LOAD, 1'b0, "mto_decode");
    for (int i = 0; i < WAIT_MAX; i++) step(C_REQ | C_ASEL, 1'b0, OP_LOAD, 1'b0, "mto_wait");
    exp_fault = 1'b1;
    parked(3, "mto_park");

    do_reset();
    start_run();
    run_instr(OP_NOP, 0, 0, 1'b0);
    run_instr(OP_ADD, 0, 0, 1'b0);
    step(C_REQ | C_IRLD | C_PCINC, 1'b1, 4'($urandom), 1'b0, "ar_fetch");
    step(13'h0, 1'b0, OP_STORE, 1'b0, "ar_decode");
    step(C_REQ | C_WE | C_ASEL, 1'b0, OP_STORE, 1'b0, "ar_mem");
    rst_n = 1'b0;
    #1;
    check("ar_ctrl", 32'(ctrl), 32'(0));
    check("ar_cnt",  32'(instr_cnt), 32'(0));
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(13'h0, 1'b1, OP_STORE, 1'b0, "ar_start");

    do_reset();
    start_run();
    for (int i = 0; i < (1 << CNT_W) + 1; i++) run_instr(OP_NOP, 0, 0, 1'b0);
    check("wrap_cnt", 32'(instr_cnt), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control unit for the 8-bit COA CPU datapath (PC, IR, accumulator/register file, ALU, unified memory, 8-bit Dis output register).
- Sequences fetch, decode, execute, memory access and write-back, one state per cycle, with a ready handshake to memory.
- Detects HALT, illegal opcodes and memory timeouts.
- Counts retired instructions for debug.

Parameters:
- WAIT_MAX, 15: maximum cycles `mem_req` may stay high without `mem_ready` before a fault is raised.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- go  in  1  leave START and begin execution
- opcode  in  4  IR[7:4], valid from DECODE onward
- zero_flag  in  1  accumulator-zero flag from datapath
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write enable (qualifies mem_req)
- addr_sel  out  1  0 = PC, 1 = IR operand
- ir_ld  out  1  load IR from memory data
- pc_inc  out  1  PC <= PC+1
- pc_load  out  1  PC <= IR operand
- alu_op  out  3  0 pass, 1 add, 2 sub, 3 and
- wb_sel  out  1  0 = ALU result, 1 = memory data
- reg_we  out  1  accumulator write enable
- flag_we  out  1  zero-flag update enable
- out_ld  out  1  load Dis register from accumulator
- halted  out  1  sticky, HALT executed
- fault  out  1  sticky, illegal opcode or timeout
- instr_cnt  out  CNT_W  retired instructions

Behaviour:
- Clock `CLK`; reset `RST_N` is asynchronous, active-low.
- Reset: state = START; `halted`, `fault`, `instr_cnt` and the wait counter are cleared to 0; all control outputs are 0.
- Reset asserted mid-instruction aborts immediately. No memory write completes after `RST_N` falls.
- State register plus `halted`, `fault`, `instr_cnt` and wait counter are flops. All control outputs are combinational from state, `opcode`, `zero_flag` and `mem_ready`.
- Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 AND, 6 JMP, 7 JZ, 8 OUT, F HALT, others illegal.
- Instruction retires on the cycle it returns to FETCH (or enters HALT); `instr_cnt` +1 on that edge, wraps at 2^CNT_W-1 -> 0.
- START: all outputs 0. `go` = 1 -> FETCH.
- FETCH: `mem_req` = 1, `addr_sel` = 0.
  - If `mem_ready`: `ir_ld` = 1, `pc_inc` = 1, next DECODE.
  - Else stay.
- DECODE (1 cycle):
  - NOP -> FETCH.
  - ADD/SUB/AND -> EXEC.
  - LOAD/STORE -> MEM.
  - JMP: `pc_load` = 1 -> FETCH.
  - JZ: `pc_load` = `zero_flag` -> FETCH.
  - OUT: `out_ld` = 1 -> FETCH.
  - HALT -> HALT.
  - Illegal -> FAULT.
- EXEC: `alu_op` per opcode (1/2/3) -> WB.
- MEM: `mem_req` = 1, `addr_sel` = 1, `mem_we` = 1 for STORE.
  - On `mem_ready`: LOAD -> WB with `wb_sel` = 1; STORE -> FETCH.
  - Else stay.
- WB: `reg_we` = 1, `flag_we` = 1, `wb_sel` = 1 for LOAD else 0, `alu_op` held -> FETCH.
- `alu_op` is 0 in all states except EXEC/WB of ADD/SUB/AND.
- Minimum latencies with zero-wait memory (`mem_ready` same cycle):
  - NOP/JMP/JZ/OUT: 2 cycles.
  - STORE: 3 cycles.
  - ALU ops and LOAD: 4 cycles.
- Timeout: the wait counter increments each cycle `mem_req` = 1 and `mem_ready` = 0, and clears on any other cycle. When it reaches WAIT_MAX in FETCH or MEM -> FAULT. `mem_ready` in the same cycle as the threshold wins (request completes normally).
- HALT: `halted` = 1, all control outputs 0. Exit only by reset; `go` is ignored.
- FAULT: `fault` = 1, all control outputs 0. Exit only by reset. `instr_cnt` does not increment for the faulting instruction.
- `mem_ready` outside FETCH/MEM is ignored.

Decomposition:
- Shared package `cpu_pkg` holds:
  - opcode constants (OP_NOP..OP_HALT);
  - ALU op codes (ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND);
  - state encoding (START, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT; 3-bit).
- Sub-module `mem_wait_timer`: wait counter with clear/enable, WAIT_MAX compare and `expired` output. Everything else stays in `cpu_ctrl_fsm`.

Test Plan:
- Reset then `go` = 1; program LOAD, ADD, OUT with `mem_ready` tied 1 -> state sequence FETCH DECODE MEM WB FETCH DECODE EXEC WB FETCH DECODE FETCH; `out_ld` pulses once; `instr_cnt` = 3.
- JZ with `zero_flag` = 1, then JZ with `zero_flag` = 0 -> `pc_load` = 1 in the first DECODE only; `pc_inc` = 1 in both FETCHes.
- STORE with `mem_ready` delayed 3 cycles -> `mem_req` = `mem_we` = `addr_sel` = 1 for 4 cycles, then FETCH; no fault.
- `mem_ready` held 0 in FETCH -> FAULT entered after exactly 15 wait cycles; `fault` = 1; all outputs 0; `go` pulse has no effect.
- Opcode 0xB -> FAULT from DECODE, `instr_cnt` unchanged. Opcode 0xF -> `halted` = 1, `instr_cnt` +1.
- `RST_N` dropped during MEM of a STORE -> `mem_req`/`mem_we` fall asynchronously, state START; `instr_cnt` = 0. Also preload `instr_cnt` near 0xFFFF with 2 NOPs -> wraps to 0x0001.
